pass_lock_ctrl: RTL

PASS_LOCK_CTRL -- requirements
Module: pass_lock_ctrl

---
 rtl/pass_lock_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/pass_lock_ctrl.sv
// pass_lock_ctrl: keypad password lock FSM with lockout and relock timers; PASS_LOCK_PW_CHANGE_EN enables the SET state.
module pass_lock_ctrl #(
  parameter int DIGITS = 4,
  parameter logic [4*DIGITS-1:0] DEFAULT_PW = 16'h1234,
  parameter int MAX_ERR = 3,
  parameter int LOCKOUT_CYC = 100,
  parameter int UNLOCK_CYC = 50
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                key_valid,
  input  logic [3:0]          key_val,
  input  logic                confirm,
  input  logic                exit_btn,
  input  logic                set_req,
  output logic [1:0]          state,
  output logic                unlocked,
  output logic [2:0]          err_cnt,
  output logic [4*DIGITS-1:0] entry_disp,
  output logic [3:0]          entry_cnt,
  output logic                pw_changed
);
  localparam int W = 4 * DIGITS;
  localparam int TMAX = LOCKOUT_CYC > UNLOCK_CYC ? LOCKOUT_CYC : UNLOCK_CYC;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [1:0] S_LOCKED = 2'd0, S_OPEN = 2'd1, S_SET = 2'd2, S_LOCKOUT = 2'd3;
  localparam logic [TW-1:0] T_OPEN = TW'(UNLOCK_CYC - 1), T_LOCK = TW'(LOCKOUT_CYC - 1);
  logic [TW-1:0] timer;
  logic [W-1:0]  pw;
  logic          set_en, full, cap, submit, set_go, shift, clr;
`ifdef PASS_LOCK_PW_CHANGE_EN
  assign set_en = set_req;
`else
  logic unused_set;
  assign unused_set = set_req;
  assign set_en = 1'b0;
  assign pw = DEFAULT_PW;
`endif
  assign unlocked = state == S_OPEN;
  always_comb begin
    full = entry_cnt == 4'(DIGITS);
    cap = state == S_LOCKED || state == S_SET;
    submit = cap && confirm && full && !exit_btn;
    set_go = state == S_OPEN && set_en && !exit_btn && !confirm;
    shift = cap && key_valid && key_val <= 4'd9 && !full && !exit_btn && !confirm && !set_en;
    clr = (cap && exit_btn) || submit || set_go;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_LOCKED;
      timer <= '0;
      err_cnt <= '0;
      entry_disp <= '0;
      entry_cnt <= '0;
      pw_changed <= 1'b0;
`ifdef PASS_LOCK_PW_CHANGE_EN
      pw <= DEFAULT_PW;
`endif
    end else begin
      pw_changed <= 1'b0;
      if (clr) begin
        entry_disp <= '0;
        entry_cnt <= '0;
      end else if (shift) begin
        entry_disp <= (entry_disp << 4) | W'(key_val);
        entry_cnt <= entry_cnt + 4'd1;
      end
      case (state)
        S_LOCKED:
          if (submit) begin
            if (entry_disp == pw) begin
              state <= S_OPEN;
              err_cnt <= '0;
              timer <= T_OPEN;
            end else begin
              err_cnt <= err_cnt + 3'd1;
              if (err_cnt + 3'd1 == 3'(MAX_ERR)) begin
                state <= S_LOCKOUT;
                timer <= T_LOCK;
              end
            end
          end
        S_OPEN:
          if (exit_btn || (!set_go && timer == '0)) begin
            state <= S_LOCKED;
            timer <= '0;
          end else if (set_go) begin
            state <= S_SET;
            timer <= '0;
          end else timer <= timer - 1'b1;
`ifdef PASS_LOCK_PW_CHANGE_EN
        S_SET:
          if (exit_btn) begin
            state <= S_OPEN;
            timer <= T_OPEN;
          end else if (submit) begin
            pw <= entry_disp;
            pw_changed <= 1'b1;
            state <= S_LOCKED;
          end
`endif
        S_LOCKOUT:
          if (timer == '0) begin
            state <= S_LOCKED;
            err_cnt <= '0;
          end else timer <= timer - 1'b1;
        default: state <= S_LOCKED;
      endcase
    end
endmodule
